// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with switch-selected baud rate.
// A 2-flop synchronizer feeds a tick-driven FSM that samples each bit in its centre.
module uart_rx_os #(
    parameter int unsigned osc_freq     = 100_000_000,
    parameter int unsigned Data_width   = 8,
    parameter int unsigned no_of_sample = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            sw,
    input  logic                  rx_din,
    output logic [Data_width-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_active,
    output logic                  frame_err
);

    localparam int unsigned DIV_MAX = osc_freq / (9600 * no_of_sample);
    localparam int unsigned TW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int unsigned SW      = $clog2(no_of_sample);
    localparam int unsigned BW      = $clog2(Data_width + 1);

    function automatic logic [TW-1:0] div_m1(input int unsigned baud);
        return TW'(osc_freq / (baud * no_of_sample) - 1);
    endfunction

    // Terminal tick-counter values per switch setting, folded at elaboration.
    localparam logic [TW-1:0] DIV_M1 [8] = '{
        div_m1(9600),   div_m1(19200),  div_m1(38400),  div_m1(57600),
        div_m1(115200), div_m1(230400), div_m1(460800), div_m1(921600)
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic                  armed_q, armed_d;
    logic [2:0]            baud_sel_q, baud_sel_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]         sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [Data_width-1:0] shift_q, shift_d;
    logic [Data_width-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  rxs;
    logic                  tick;

    assign rxs = sync2_q;
    assign tick = (tick_cnt_q == DIV_M1[baud_sel_q]);

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        baud_sel_d   = baud_sel_q;
        tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_cnt_d   = '0;
                sample_cnt_d = '0;
                baud_sel_d   = sw;
                // Arming needs rxs high for a cycle, so a held break never restarts a frame.
                if (armed_q && !rxs) begin
                    state_d = S_START;
                    armed_d = 1'b0;
                end else begin
                    armed_d = armed_q | rxs;
                end
            end
            S_START: begin
                if (tick) begin
                    if (sample_cnt_q == SW'(no_of_sample / 2 - 1)) begin
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                        if (!rxs) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                            armed_d = 1'b1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (sample_cnt_q == SW'(no_of_sample - 1)) begin
                        sample_cnt_d = '0;
                        shift_d      = {rxs, shift_q[Data_width-1:1]};
                        bit_cnt_d    = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BW'(Data_width - 1)) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (sample_cnt_q == SW'(no_of_sample - 1)) begin
                        sample_cnt_d = '0;
                        state_d      = S_IDLE;
                        armed_d      = rxs;
                        if (rxs) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= S_IDLE;
            armed_q      <= 1'b0;
            baud_sel_q   <= '0;
            tick_cnt_q   <= '0;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= rx_din;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            armed_q      <= armed_d;
            baud_sel_q   <= baud_sel_d;
            tick_cnt_q   <= tick_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_active = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: serial frames built from a baud table model, strobes collected by a monitor.
module tb_uart_rx_os;

    localparam int unsigned OSC = 16_000_000;
    localparam int unsigned NS  = 16;
    localparam int unsigned BAUD [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] sw = 3'd0;
    logic       rx_din = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    byte unsigned got_q[$];
    int unsigned  valid_cnt = 0;
    int unsigned  err_cnt = 0;
    int unsigned  overlap_cnt = 0;
    int unsigned  long_cnt = 0;
    logic         prev_v = 1'b0;
    logic         prev_e = 1'b0;
    logic [7:0]   exp_data = 8'h00;

    always #5 clock = ~clock;

    uart_rx_os #(
        .osc_freq    (OSC),
        .Data_width  (8),
        .no_of_sample(NS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sw       (sw),
        .rx_din   (rx_din),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_active(rx_active),
        .frame_err(frame_err)
    );

    always @(negedge clock) begin
        if (rx_valid) begin
            valid_cnt = valid_cnt + 1;
            got_q.push_back(rx_data);
        end
        if (frame_err) err_cnt = err_cnt + 1;
        if (rx_valid && frame_err) overlap_cnt = overlap_cnt + 1;
        if ((rx_valid && prev_v) || (frame_err && prev_e)) long_cnt = long_cnt + 1;
        prev_v = rx_valid;
        prev_e = frame_err;
    end

    function automatic int unsigned bit_period(input int unsigned s);
        return (OSC / (BAUD[s] * NS)) * NS;
    endfunction

    task automatic drive(input logic v, input int unsigned n);
        rx_din = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input int unsigned p, input logic stop);
        drive(1'b0, p);
        for (int i = 0; i < 8; i++) drive(d[i], p);
        drive(stop, p);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx_din = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++;
        if (rx_active !== 1'b0) begin errors++; $display("FAIL reset_rx_active: got %b want 0", rx_active); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        reset = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_basic;
        int unsigned p = bit_period(4);
        int unsigned v0 = valid_cnt;
        int unsigned e0 = err_cnt;
        int unsigned b0 = got_q.size();
        sw = 3'd4;
        repeat (2) @(negedge clock);
        fork
            send_frame(8'hA5, p, 1'b1);
            begin
                @(negedge clock);
                checks++;
                if (rx_active !== 1'b0) begin errors++; $display("FAIL active_early: got %b want 0", rx_active); end
                repeat (3) @(negedge clock);
                checks++;
                if (rx_active !== 1'b1) begin errors++; $display("FAIL active_start: got %b want 1", rx_active); end
                repeat (5 * p) @(negedge clock);
                checks++;
                if (rx_active !== 1'b1) begin errors++; $display("FAIL active_mid: got %b want 1", rx_active); end
            end
        join
        drive(1'b1, p);
        exp_data = 8'hA5;
        checks++;
        if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_count: got %0d want 1", valid_cnt - v0); end
        checks++;
        if (got_q.size() > b0 && got_q[b0] !== exp_data) begin
            errors++; $display("FAIL basic_data: got %h want %h", got_q[b0], exp_data);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL basic_frame_err: got %0d want 0", err_cnt - e0); end
        checks++;
        if (rx_active !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", rx_active); end
    endtask

    task automatic test_back_to_back;
        int unsigned p = bit_period(0);
        int unsigned v0 = valid_cnt;
        int unsigned b0 = got_q.size();
        sw = 3'd0;
        repeat (4) @(negedge clock);
        send_frame(8'h00, p, 1'b1);
        send_frame(8'hFF, p, 1'b1);
        drive(1'b1, 16);
        exp_data = 8'hFF;
        checks++;
        if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", valid_cnt - v0); end
        checks++;
        if (got_q.size() > b0 + 1 && (got_q[b0] !== 8'h00 || got_q[b0+1] !== 8'hFF)) begin
            errors++; $display("FAIL b2b_data: got %h %h want 00 ff", got_q[b0], got_q[b0+1]);
        end
    endtask

    task automatic test_frame_err;
        int unsigned p = bit_period(7);
        int unsigned v0 = valid_cnt;
        int unsigned e0 = err_cnt;
        sw = 3'd7;
        repeat (4) @(negedge clock);
        send_frame(8'h3C, p, 1'b0);
        drive(1'b0, 20 * p);
        drive(1'b1, 2 * p);
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", err_cnt - e0); end
        checks++;
        if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", valid_cnt - v0); end
        checks++;
        if (rx_data !== exp_data) begin errors++; $display("FAIL ferr_rx_data: got %h want %h", rx_data, exp_data); end
    endtask

    task automatic test_glitch;
        int unsigned p = bit_period(4);
        int unsigned v0 = valid_cnt;
        int unsigned e0 = err_cnt;
        sw = 3'd4;
        repeat (4) @(negedge clock);
        drive(1'b0, 3 * (p / NS));
        drive(1'b1, p);
        checks++;
        if (rx_active !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b want 0", rx_active); end
        checks++;
        if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL glitch_strobes: got valid %0d err %0d want 0 0", valid_cnt - v0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid;
        int unsigned p = bit_period(4);
        logic [7:0] d = 8'h5A;
        int unsigned v0;
        int unsigned b0;
        sw = 3'd4;
        v0 = valid_cnt;
        repeat (4) @(negedge clock);
        drive(1'b0, p);
        for (int i = 0; i < 4; i++) drive(d[i], p);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rx_din = 1'b1;
        checks++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_active !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got data %h v %b a %b e %b want 00 0 0 0",
                               rx_data, rx_valid, rx_active, frame_err);
        end
        drive(1'b1, 2 * p);
        checks++;
        if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL midreset_valid: got %0d want 0", valid_cnt - v0); end
        exp_data = 8'h00;
        v0 = valid_cnt;
        b0 = got_q.size();
        send_frame(d, p, 1'b1);
        drive(1'b1, 16);
        exp_data = d;
        checks++;
        if (valid_cnt - v0 !== 1 || got_q.size() <= b0 || got_q[b0] !== d) begin
            errors++; $display("FAIL midreset_refetch: got count %0d data %h want 1 %h",
                               valid_cnt - v0, rx_data, d);
        end
    endtask

    task automatic test_sw_change;
        int unsigned p4 = bit_period(4);
        int unsigned p0 = bit_period(0);
        logic [7:0] d2 = 8'($urandom);
        int unsigned v0 = valid_cnt;
        int unsigned b0 = got_q.size();
        sw = 3'd4;
        repeat (4) @(negedge clock);
        fork
            send_frame(8'h81, p4, 1'b1);
            begin
                repeat (3 * p4) @(negedge clock);
                sw = 3'd0;
            end
        join
        drive(1'b1, 16);
        checks++;
        if (valid_cnt - v0 !== 1 || got_q.size() <= b0 || got_q[b0] !== 8'h81) begin
            errors++; $display("FAIL swchg_first: got count %0d data %h want 1 81", valid_cnt - v0, rx_data);
        end
        send_frame(d2, p0, 1'b1);
        drive(1'b1, 16);
        exp_data = d2;
        checks++;
        if (valid_cnt - v0 !== 2 || got_q.size() <= b0 + 1 || got_q[b0+1] !== d2) begin
            errors++; $display("FAIL swchg_second: got count %0d data %h want 2 %h", valid_cnt - v0, rx_data, d2);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++) begin
            int unsigned s = $urandom_range(2, 7);
            logic [7:0] d = 8'($urandom);
            logic stop = ($urandom_range(0, 3) != 0);
            int unsigned p = bit_period(s);
            int unsigned v0 = valid_cnt;
            int unsigned e0 = err_cnt;
            sw = 3'(s);
            repeat (4) @(negedge clock);
            send_frame(d, p, stop);
            drive(1'b1, 2 * p);
            if (stop) exp_data = d;
            checks++;
            if (valid_cnt - v0 !== (stop ? 1 : 0) || err_cnt - e0 !== (stop ? 0 : 1)) begin
                errors++; $display("FAIL rand_strobes[%0d]: got valid %0d err %0d want %0d %0d",
                                   n, valid_cnt - v0, err_cnt - e0, stop ? 1 : 0, stop ? 0 : 1);
            end
            checks++;
            if (rx_data !== exp_data) begin
                errors++; $display("FAIL rand_data[%0d]: got %h want %h", n, rx_data, exp_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_sw_change();
        test_random();
        checks++;
        if (overlap_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", overlap_cnt); end
        checks++;
        if (long_cnt !== 0) begin errors++; $display("FAIL strobe_width: got %0d want 0", long_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver that feeds received bytes to the loopback/transmit side of the UART top level.
- Accepts the asynchronous serial line `rx_din` and selects its baud rate from the 3-bit board switch bus `sw`.
- Recovers 8N1 frames using `no_of_sample`× oversampling with mid-bit sampling.
- Presents each received byte with a one-cycle valid strobe, a busy indication and a framing-error strobe.

Parameters:
- osc_freq, 100_000_000, system clock frequency in Hz.
- Data_width, 8, data bits per frame, LSB first.
- no_of_sample, 16, oversampling ticks per bit; must be even and ≥ 4.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sw  input  3  baud select.
- rx_din  input  1  asynchronous serial line, idle high.
- rx_data  output  Data_width  last good received byte.
- rx_valid  output  1  one-cycle pulse; rx_data updated with it.
- rx_active  output  1  high while a frame is being received.
- frame_err  output  1  one-cycle pulse on bad stop bit.

Behaviour:
- One clock; reset is synchronous and active-high, named `reset`, sampled on the rising edge of `clock`.
- Reset values:
  - rx_data = 0, rx_valid = 0, rx_active = 0, frame_err = 0.
  - Synchronizer flops = 1, state = IDLE, all counters = 0.
- Reset asserted mid-frame aborts the frame; outputs hold reset values from the next edge.
- Input synchronizer: 2-flop on rx_din; all logic uses the second flop (rxs). This adds 2 cycles of latency.
- Baud table, selected by sw: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600.
- Tick divisor: DIV = floor(osc_freq / (baud × no_of_sample)), computed at elaboration. At default parameters this gives 651, 325, 162, 108, 54, 27, 13, 6.
- sw is latched into baud_sel only in IDLE. Changing sw mid-frame has no effect on the current frame.
- Tick generator:
  - Counter runs 0..DIV−1; tick = 1 for one cycle when the counter equals DIV−1.
  - Counter is cleared in IDLE and on the IDLE→START transition.
- States:
  - IDLE:
    - rx_active = 0.
    - The receiver is armed once rxs has been 1 for at least one cycle.
    - Armed and rxs = 0 → START, clear tick and sample counters.
  - START:
    - Count ticks. On the tick where sample count = no_of_sample/2 − 1 (mid start bit):
      - rxs = 0 → DATA, clear sample count and bit count.
      - rxs = 1 → false start; return to IDLE with no strobes.
  - DATA:
    - On the tick where sample count = no_of_sample − 1: shift rxs into the shift register MSB side (LSB-first reassembly), bit_cnt++, clear sample count.
    - After Data_width bits → STOP.
  - STOP:
    - On the tick where sample count = no_of_sample − 1:
      - rxs = 1 → rx_data ← shift register, rx_valid = 1 on the next cycle.
      - rxs = 0 → frame_err = 1 on the next cycle; rx_data unchanged.
    - Either way → IDLE.
- rx_active = 1 in START, DATA and STOP.
- After a frame error the line may be held low (break). IDLE is not re-armed until rxs = 1, so no spurious frame is received.
- rx_valid and frame_err are never asserted in the same cycle, and each lasts exactly one cycle.
- No backpressure: the consumer must take rx_data when rx_valid pulses. rx_data holds until the next good frame.
- Back-to-back frames: a start edge immediately after the stop-bit sample is accepted, because the stop bit re-arms IDLE.

Test Plan:
- sw=4 (DIV=54), send 0xA5 8N1 at 115200 baud:
  - rx_valid pulses once with rx_data=0xA5, frame_err=0.
  - rx_active high from about 3 cycles after the start edge until the stop sample.
- sw=0, send 0x00 then 0xFF back-to-back with no idle gap: two rx_valid pulses, data 0x00 then 0xFF.
- sw=7, send 0x3C with the stop bit forced low, then hold the line low 20 bit times: exactly one frame_err pulse, no rx_valid, rx_data keeps its previous value, no further frames.
- Glitch test: rx_din low for 3 bit-ticks (< no_of_sample/2) at sw=4 → no rx_active beyond the START check, no strobes, returns to IDLE.
- Assert reset for one cycle midway through the data bits of 0x5A: all outputs zero the next cycle, no rx_valid; the following 0x5A frame is received correctly.
- Change sw from 4 to 0 during the data bits of 0x81 at 115200: byte received correctly as 0x81; the next frame at 9600 is received correctly.
